// File: rtl/tank_pkg.sv
// Shared types and constants for the tank game enemy logic.
// Spawn coordinates are screen pixel positions of each spawn point.
package tank_pkg;

  typedef enum logic [1:0] {
    ACTIVE  = 2'd0,
    WAIT    = 2'd1,
    PENDING = 2'd2,
    RETIRED = 2'd3
  } enemy_slot_t;

  localparam int unsigned NUM_ENEMY_DEF = 3;
  localparam int unsigned NUM_SPAWN_DEF = 3;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } spawn_xy_t;

  localparam spawn_xy_t SPAWN_XY [NUM_SPAWN_DEF] = '{
    '{x: 10'd32,  y: 10'd32},
    '{x: 10'd192, y: 10'd32},
    '{x: 10'd512, y: 10'd32}
  };

  function automatic spawn_xy_t spawn_coord(input logic [1:0] idx);
    spawn_coord = (idx < 2'(NUM_SPAWN_DEF)) ? SPAWN_XY[idx] : SPAWN_XY[0];
  endfunction

endpackage

// File: rtl/enemy_spawn_ctrl_rr_arbiter.sv
// Round-robin arbiter: searches requests starting just after the last
// granted index, wrapping modulo N, and returns a one-hot grant.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  logic [LW-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    if (en) begin
      for (int unsigned off = 1; off <= N; off++) begin
        idx = LW'((32'(last) + off) % N);
        if (!valid && req[idx]) begin
          gnt[idx] = 1'b1;
          valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/enemy_spawn_ctrl.sv
// Enemy respawn sequencer: per-enemy delay state machines, reserve pool,
// round-robin spawn arbitration (one grant per frame), kill/level-clear reporting.
module enemy_spawn_ctrl
  import tank_pkg::*;
#(
  parameter int unsigned NUM_ENEMY   = NUM_ENEMY_DEF,
  parameter int unsigned NUM_SPAWN   = NUM_SPAWN_DEF,
  parameter int unsigned RESERVE     = 20,
  parameter int unsigned SPAWN_DELAY = 60
) (
  input  logic                 clk_50MHz,
  input  logic                 reset,
  input  logic                 refresh_tick,
  input  logic [NUM_ENEMY-1:0] destroyed,
  input  logic [NUM_SPAWN-1:0] spawn_clear,
  output logic [NUM_ENEMY-1:0] spawn_grant,
  output logic [1:0]           spawn_point,
  output logic [NUM_ENEMY-1:0] enemy_active,
  output logic [7:0]           reserve_left,
  output logic [7:0]           kill_count,
  output logic                 level_clear
);

  localparam int unsigned LW = (NUM_ENEMY > 1) ? $clog2(NUM_ENEMY) : 1;

  enemy_slot_t          state_q [NUM_ENEMY];
  enemy_slot_t          state_d [NUM_ENEMY];
  logic [7:0]           cnt_q   [NUM_ENEMY];
  logic [7:0]           cnt_d   [NUM_ENEMY];

  logic [NUM_ENEMY-1:0] req;
  logic [NUM_ENEMY-1:0] gnt;
  logic                 arb_valid;
  logic                 arb_en;
  logic [LW-1:0]        gnt_idx;

  logic [LW-1:0]        last_q, last_d;
  logic [1:0]           sp_q, sp_d;
  logic [7:0]           reserve_q, reserve_d;
  logic [7:0]           kill_q, kill_d;
  logic                 clear_q, clear_d;
  logic [NUM_ENEMY-1:0] grant_q, grant_d;
  logic [1:0]           point_q, point_d;
  logic                 all_retired;

  always_comb begin
    all_retired = 1'b1;
    for (int unsigned i = 0; i < NUM_ENEMY; i++) begin
      req[i] = (state_q[i] == PENDING);
      if (state_q[i] != RETIRED) all_retired = 1'b0;
    end
  end

  // Gating on reserve keeps reserve_left from underflowing and lets
  // stranded PENDING enemies retire instead of winning a grant.
  assign arb_en = refresh_tick && !clear_q && (reserve_q != '0);

  rr_arbiter #(.N(NUM_ENEMY)) u_arb (
    .req   (req),
    .en    (arb_en),
    .last  (last_q),
    .gnt   (gnt),
    .valid (arb_valid)
  );

  always_comb begin
    gnt_idx = last_q;
    for (int unsigned i = 0; i < NUM_ENEMY; i++) begin
      if (gnt[i]) gnt_idx = LW'(i);
    end
  end

  // Shared arbitration and bookkeeping
  always_comb begin
    grant_d   = '0;
    point_d   = '0;
    sp_d      = sp_q;
    last_d    = last_q;
    reserve_d = reserve_q;
    if (arb_valid) begin
      sp_d = (sp_q == 2'(NUM_SPAWN - 1)) ? '0 : sp_q + 2'd1;
      if (spawn_clear[sp_q]) begin
        grant_d   = gnt;
        point_d   = sp_q;
        reserve_d = reserve_q - 8'd1;
        last_d    = gnt_idx;
      end
    end
    clear_d = clear_q || (all_retired && (reserve_q == '0));
  end

  // Per-enemy state machines
  always_comb begin
    kill_d = kill_q;
    for (int unsigned i = 0; i < NUM_ENEMY; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ACTIVE: begin
          if (destroyed[i]) begin
            state_d[i] = WAIT;
            cnt_d[i]   = 8'(SPAWN_DELAY);
            if (kill_d != 8'hFF) kill_d = kill_d + 8'd1;
          end
        end
        WAIT: begin
          if (refresh_tick) begin
            if (cnt_q[i] <= 8'd1) state_d[i] = PENDING;
            else                  cnt_d[i]   = cnt_q[i] - 8'd1;
          end
        end
        PENDING: begin
          if (refresh_tick) begin
            if (reserve_q == '0)  state_d[i] = RETIRED;
            else if (grant_d[i])  state_d[i] = ACTIVE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_ENEMY; i++) begin
        state_q[i] <= ACTIVE;
        cnt_q[i]   <= 8'(SPAWN_DELAY);
      end
      last_q    <= LW'(NUM_ENEMY - 1);
      sp_q      <= '0;
      reserve_q <= 8'(RESERVE);
      kill_q    <= '0;
      clear_q   <= 1'b0;
      grant_q   <= '0;
      point_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENEMY; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      last_q    <= last_d;
      sp_q      <= sp_d;
      reserve_q <= reserve_d;
      kill_q    <= kill_d;
      clear_q   <= clear_d;
      grant_q   <= grant_d;
      point_q   <= point_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_ENEMY; i++) begin
      enemy_active[i] = (state_q[i] == ACTIVE);
    end
  end

  assign spawn_grant  = grant_q;
  assign spawn_point  = point_q;
  assign reserve_left = reserve_q;
  assign kill_count   = kill_q;
  assign level_clear  = clear_q;

endmodule

// File: tb/tb_enemy_spawn_ctrl.sv
// Bench for enemy_spawn_ctrl: directed scenarios then randomized traffic,
// all checked against a frame-count based reference model.
module tb_enemy_spawn_ctrl;

  localparam int NE    = 3;
  localparam int RES   = 3;
  localparam int DELAY = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          refresh_tick;
  logic [NE-1:0] destroyed;
  logic [2:0]    spawn_clear;
  logic [NE-1:0] spawn_grant;
  logic [1:0]    spawn_point;
  logic [NE-1:0] enemy_active;
  logic [7:0]    reserve_left;
  logic [7:0]    kill_count;
  logic          level_clear;

  int checks = 0;
  int errors = 0;

  enemy_spawn_ctrl #(
    .NUM_ENEMY   (NE),
    .NUM_SPAWN   (3),
    .RESERVE     (RES),
    .SPAWN_DELAY (DELAY)
  ) dut (
    .clk_50MHz    (clk),
    .reset        (reset),
    .refresh_tick (refresh_tick),
    .destroyed    (destroyed),
    .spawn_clear  (spawn_clear),
    .spawn_grant  (spawn_grant),
    .spawn_point  (spawn_point),
    .enemy_active (enemy_active),
    .reserve_left (reserve_left),
    .kill_count   (kill_count),
    .level_clear  (level_clear)
  );

  always #10 clk = ~clk;

  // Reference model: an enemy killed when T frames have elapsed may spawn
  // on any frame strictly after frame T+DELAY.
  int         m_tick = 0;
  bit         m_alive   [NE];
  bit         m_retired [NE];
  int         m_ready   [NE];
  int         m_reserve, m_kill, m_sp, m_last, m_point;
  bit         m_clear;
  logic [2:0] m_grant;

  function automatic bit eligible(input int i);
    return !m_alive[i] && !m_retired[i] && (m_tick > m_ready[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_alive[i] = 1'b1; m_retired[i] = 1'b0; m_ready[i] = 0;
    end
    m_reserve = RES; m_kill = 0; m_sp = 0; m_last = NE - 1;
    m_point = 0; m_clear = 1'b0; m_grant = '0;
  endtask

  task automatic model_step(input logic t, input logic [2:0] d, input logic [2:0] c);
    int  res_old;
    bit  clr_old, allret, k_found;
    bit  alive_old [NE];
    int  k;
    res_old = m_reserve;
    clr_old = m_clear;
    allret  = 1'b1;
    for (int i = 0; i < NE; i++) begin
      alive_old[i] = m_alive[i];
      if (!m_retired[i]) allret = 1'b0;
    end
    if (t) m_tick++;
    m_grant = '0;
    if (t && !clr_old && res_old > 0) begin
      k_found = 1'b0; k = 0;
      for (int n = 1; n <= NE; n++) begin
        if (!k_found && eligible((m_last + n) % NE)) begin
          k = (m_last + n) % NE; k_found = 1'b1;
        end
      end
      if (k_found) begin
        if (c[m_sp] == 1'b1) begin
          m_grant[k] = 1'b1; m_point = m_sp; m_reserve--;
          m_last = k; m_alive[k] = 1'b1;
        end
        m_sp = (m_sp + 1) % 3;
      end
    end
    if (t && res_old == 0) begin
      for (int i = 0; i < NE; i++) if (eligible(i)) m_retired[i] = 1'b1;
    end
    for (int i = 0; i < NE; i++) begin
      if (alive_old[i] && d[i] == 1'b1) begin
        m_alive[i] = 1'b0;
        m_ready[i] = m_tick + DELAY;
        if (m_kill < 255) m_kill++;
      end
    end
    if (!clr_old && allret && res_old == 0) m_clear = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [2:0] act;
    for (int i = 0; i < NE; i++) act[i] = m_alive[i];
    chk("grant", 8'(spawn_grant), 8'(m_grant));
    if (m_grant != '0) chk("point", 8'(spawn_point), 8'(m_point));
    chk("active", 8'(enemy_active), 8'(act));
    chk("reserve", reserve_left, 8'(m_reserve));
    chk("kills", kill_count, 8'(m_kill));
    chk("clear", 8'(level_clear), 8'(m_clear));
  endtask

  task automatic cycle(input logic r, input logic t, input logic [2:0] d, input logic [2:0] c);
    @(negedge clk);
    reset = r; refresh_tick = t; destroyed = d; spawn_clear = c;
    @(posedge clk);
    if (!r) model_reset();
    else    model_step(t, d, c);
    #1;
    check_model();
  endtask

  initial begin
    reset = 1'b0; refresh_tick = 1'b0; destroyed = '0; spawn_clear = '1;
    model_reset();

    // Reset state
    cycle(0, 0, 3'b000, 3'b111);
    cycle(0, 1, 3'b111, 3'b111);
    chk("rst_active", 8'(enemy_active), 8'h07);
    chk("rst_reserve", reserve_left, 8'd3);
    chk("rst_grant", 8'(spawn_grant), 8'h00);

    // Single kill, delayed respawn at spawn point 0
    cycle(1, 0, 3'b001, 3'b111);
    cycle(1, 1, 3'b000, 3'b111);
    cycle(1, 0, 3'b000, 3'b111);
    cycle(1, 1, 3'b000, 3'b111);
    chk("pre_grant", 8'(spawn_grant), 8'h00);
    cycle(1, 1, 3'b000, 3'b111);
    chk("g0_grant", 8'(spawn_grant), 8'h01);
    chk("g0_point", 8'(spawn_point), 8'd0);
    chk("g0_kills", kill_count, 8'd1);
    cycle(1, 0, 3'b000, 3'b111);
    chk("g0_pulse", 8'(spawn_grant), 8'h00);

    // Double kill: grants on consecutive frames, points 1 then 2
    cycle(1, 0, 3'b110, 3'b111);
    chk("dbl_kills", kill_count, 8'd3);
    repeat (3) cycle(1, 1, 3'b000, 3'b111);
    chk("g1_grant", 8'(spawn_grant), 8'h02);
    chk("g1_point", 8'(spawn_point), 8'd1);
    cycle(1, 1, 3'b000, 3'b111);
    chk("g2_grant", 8'(spawn_grant), 8'h04);
    chk("g2_point", 8'(spawn_point), 8'd2);
    chk("g2_reserve", reserve_left, 8'd0);

    // Reserve exhausted: all retire, level clears, retired kills ignored
    cycle(1, 0, 3'b111, 3'b111);
    repeat (4) cycle(1, 1, 3'b000, 3'b111);
    cycle(1, 0, 3'b000, 3'b111);
    chk("lvl_clear", 8'(level_clear), 8'd1);
    cycle(1, 1, 3'b111, 3'b111);
    chk("retired_kills", kill_count, 8'd6);

    // Blocked spawn point is skipped
    cycle(0, 0, 3'b000, 3'b111);
    cycle(1, 0, 3'b001, 3'b110);
    repeat (3) cycle(1, 1, 3'b000, 3'b110);
    chk("blk_nogrant", 8'(spawn_grant), 8'h00);
    cycle(1, 1, 3'b000, 3'b110);
    chk("blk_grant", 8'(spawn_grant), 8'h01);
    chk("blk_point", 8'(spawn_point), 8'd1);

    // Reset while an enemy is waiting
    cycle(1, 0, 3'b010, 3'b111);
    cycle(1, 1, 3'b000, 3'b111);
    cycle(0, 1, 3'b000, 3'b111);
    chk("midrst_active", 8'(enemy_active), 8'h07);
    chk("midrst_kills", kill_count, 8'd0);
    repeat (3) cycle(1, 1, 3'b000, 3'b111);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic       r, t;
      logic [2:0] d, c;
      r = ($urandom_range(0, 199) != 0);
      t = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      c = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      cycle(r, t, d, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
